// File: rtl/bitonic_sort_sched.sv
// Sequential bitonic sorter: one registered compare-exchange per cycle, walked
// through every network step by a stage/distance/pair counter FSM.
module bitonic_sort_sched #(
  parameter int N    = 8,
  parameter int W    = 8,
  parameter int LOGN = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*W-1:0] in_data,
  input  logic           in_desc,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*W-1:0] out_data,
  output logic           busy
);
  localparam int PW = LOGN - 1;
  localparam logic [PW-1:0]   P_LAST  = PW'(N/2 - 1);
  localparam logic [LOGN-1:0] KS_LAST = LOGN'(LOGN);

  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;
  state_t state, state_nx;

  logic [N-1:0][W-1:0] a;
  logic                desc;
  logic [LOGN-1:0]     ks;   // k = 2^ks
  logic [LOGN-1:0]     s;    // j = 2^s
  logic [PW-1:0]       p;
  logic                accept, last_step, up, swap;
  logic [LOGN-1:0]     pe, jv, i_idx, l_idx;
  logic [LOGN:0]       kv;
  logic [W-1:0]        ai, al;

  // Pair index: insert a zero at bit s of p to get the lower element.
  always_comb begin
    pe        = LOGN'(p);
    jv        = LOGN'(1) << s;
    i_idx     = ((pe >> s) << (s + LOGN'(1))) | (pe & (jv - LOGN'(1)));
    l_idx     = i_idx | jv;
    kv        = (LOGN+1)'(1) << ks;
    up        = (({1'b0, i_idx} & kv) == '0) ^ desc;
    ai        = a[i_idx];
    al        = a[l_idx];
    swap      = up ? (ai > al) : (ai < al);
    last_step = (p == P_LAST) && (s == '0) && (ks == KS_LAST);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept   = 1'b1;
          state_nx = SORT;
        end
      end
      SORT: begin
        busy = 1'b1;
        if (last_step) state_nx = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a    <= '0;
      desc <= 1'b0;
      ks   <= '0;
      s    <= '0;
      p    <= '0;
    end else if (accept) begin
      a    <= in_data;
      desc <= in_desc;
      ks   <= LOGN'(1);
      s    <= '0;
      p    <= '0;
    end else if (state == SORT) begin
      if (swap) begin
        a[i_idx] <= al;
        a[l_idx] <= ai;
      end
      // p innermost, then j halves, then k doubles with j restarting at k/2
      if (p == P_LAST) begin
        p <= '0;
        if (s == '0) begin
          if (ks != KS_LAST) begin
            ks <= ks + LOGN'(1);
            s  <= ks;
          end
        end else begin
          s <= s - LOGN'(1);
        end
      end else begin
        p <= p + PW'(1);
      end
    end
  end

  // Array is exposed only in DONE so intermediate swaps never reach the port.
  assign out_data = (state == DONE) ? a : '0;

endmodule

// File: tb/tb_bitonic_sort_sched.sv
// Directed and random checks of bitonic_sort_sched at N=8, 4 and 16.
module tb_bitonic_sort_sched;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]        ivld, irdy, idesc, ovld, ordy, bsy;
  logic [2:0][127:0] din, dout;
  logic [63:0]       dout8;
  logic [31:0]       dout4;
  logic [127:0]      dout16;

  localparam int NEL [3]  = '{8, 4, 16};
  localparam int SLAT [3] = '{24, 6, 80};

  int ncmp = 0;
  int nerr = 0;
  int hs0  = 0;

  bitonic_sort_sched #(.N(8), .W(8)) u8 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[0]), .in_ready(irdy[0]),
    .in_data(din[0][63:0]), .in_desc(idesc[0]), .out_valid(ovld[0]),
    .out_ready(ordy[0]), .out_data(dout8), .busy(bsy[0]));
  bitonic_sort_sched #(.N(4), .W(8)) u4 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[1]), .in_ready(irdy[1]),
    .in_data(din[1][31:0]), .in_desc(idesc[1]), .out_valid(ovld[1]),
    .out_ready(ordy[1]), .out_data(dout4), .busy(bsy[1]));
  bitonic_sort_sched #(.N(16), .W(8)) u16 (
    .clk(clk), .rst_n(rst_n), .in_valid(ivld[2]), .in_ready(irdy[2]),
    .in_data(din[2]), .in_desc(idesc[2]), .out_valid(ovld[2]),
    .out_ready(ordy[2]), .out_data(dout16), .busy(bsy[2]));

  assign dout[0] = {64'd0, dout8};
  assign dout[1] = {96'd0, dout4};
  assign dout[2] = dout16;

  always @(posedge clk) if (ovld[0] && ordy[0]) hs0++;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  function automatic logic [127:0] ref_sort(input logic [127:0] v, input int n, input logic d);
    int e [16];
    int t;
    logic [127:0] r;
    for (int x = 0; x < n; x++) e[x] = int'(v[x*8 +: 8]);
    for (int x = 0; x < n; x++)
      for (int y = 0; y < n - 1 - x; y++)
        if (e[y] > e[y+1]) begin t = e[y]; e[y] = e[y+1]; e[y+1] = t; end
    r = '0;
    for (int x = 0; x < n; x++) r[x*8 +: 8] = 8'(d ? e[n-1-x] : e[x]);
    return r;
  endfunction

  // Present a vector, wait for acceptance, then count cycles until out_valid.
  task automatic send(input int sel, input logic [127:0] v, input logic d, output int lat);
    int n;
    din[sel] = v; idesc[sel] = d; ivld[sel] = 1'b1;
    n = 0;
    while (!irdy[sel] && n < 200) begin @(posedge clk); #1; n++; end
    @(posedge clk); #1;
    ivld[sel] = 1'b0;
    lat = 0;
    while (!ovld[sel] && lat < 200) begin @(posedge clk); #1; lat++; end
  endtask

  task automatic test_reset();
    #3;
    for (int sel = 0; sel < 3; sel++) begin
      ncmp++;
      if (irdy[sel] !== 1'b1 || ovld[sel] !== 1'b0 || bsy[sel] !== 1'b0 || dout[sel] !== '0) begin
        nerr++;
        $display("FAIL reset[%0d]: rdy=%b vld=%b busy=%b data=%h, required 1 0 0 0",
                 sel, irdy[sel], ovld[sel], bsy[sel], dout[sel]);
      end
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    ncmp++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      nerr++; $display("FAIL post_reset: rdy=%b vld=%b, required 1 0", irdy[0], ovld[0]);
    end
  endtask

  task automatic test_sort_basic(input logic d, input logic [63:0] exp);
    int lat;
    ordy[0] = 1'b1;
    send(0, 128'(64'h0204010600070305), d, lat);
    ncmp++;
    if (lat !== 24) begin nerr++; $display("FAIL latency_desc%0b: got %0d, required 24", d, lat); end
    ncmp++;
    if (dout[0] !== 128'(exp)) begin
      nerr++; $display("FAIL sort_desc%0b: got %h, required %h", d, dout[0], exp);
    end
    @(posedge clk); #1;
    ncmp++;
    if (irdy[0] !== 1'b1 || ovld[0] !== 1'b0) begin
      nerr++; $display("FAIL turnaround_desc%0b: rdy=%b vld=%b, required 1 0", d, irdy[0], ovld[0]);
    end
  endtask

  task automatic test_boundary(input logic [63:0] v, input logic [63:0] exp, input string nm);
    int lat;
    ordy[0] = 1'b1;
    send(0, 128'(v), 1'b0, lat);
    ncmp++;
    if (dout[0] !== 128'(exp) || lat !== 24) begin
      nerr++; $display("FAIL %s: got %h lat %0d, required %h lat 24", nm, dout[0], lat, exp);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    int n, hs_start;
    bit rdy_bad, data_bad;
    logic [127:0] d0;
    ordy[0] = 1'b0;
    hs_start = hs0;
    din[0] = 128'(64'h0204010600070305); idesc[0] = 1'b0; ivld[0] = 1'b1;
    @(posedge clk); #1;
    din[0] = 128'(64'hFFFE_FDFC_FBFA_F9F8);
    idesc[0] = 1'b1;
    rdy_bad = 0; data_bad = 0; n = 0;
    while (!ovld[0] && n < 200) begin
      if (irdy[0] !== 1'b0) rdy_bad = 1;
      if (dout[0] !== '0) data_bad = 1;
      @(posedge clk); #1; n++;
    end
    ncmp++;
    if (data_bad) begin nerr++; $display("FAIL sort_data_hidden: out_data nonzero during SORT, required 0"); end
    d0 = dout[0];
    for (int c = 0; c < 10; c++) begin
      if (irdy[0] !== 1'b0) rdy_bad = 1;
      @(posedge clk); #1;
      if (ovld[0] !== 1'b1 || dout[0] !== d0) data_bad = 1;
    end
    ncmp++;
    if (d0 !== 128'(64'h0706050403020100) || data_bad) begin
      nerr++; $display("FAIL stall_hold: got %h now %h, required stable 0706050403020100", d0, dout[0]);
    end
    ncmp++;
    if (rdy_bad) begin nerr++; $display("FAIL busy_ready: in_ready was 1 while busy, required 0"); end
    ivld[0] = 1'b0;
    ordy[0] = 1'b1;
    @(posedge clk); #1;
    ncmp++;
    if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1) begin
      nerr++; $display("FAIL stall_release: vld=%b rdy=%b, required 0 1", ovld[0], irdy[0]);
    end
    repeat (5) begin @(posedge clk); #1; end
    ncmp++;
    if (hs0 - hs_start !== 1 || bsy[0] !== 1'b0) begin
      nerr++; $display("FAIL single_handshake: got %0d handshakes busy=%b, required 1 busy=0",
                       hs0 - hs_start, bsy[0]);
    end
  endtask

  task automatic test_mid_reset();
    int lat;
    ordy[0] = 1'b1;
    din[0] = 128'(64'h0204010600070305); idesc[0] = 1'b0; ivld[0] = 1'b1;
    @(posedge clk); #1;
    ivld[0] = 1'b0;
    repeat (12) begin @(posedge clk); #1; end
    #2 rst_n = 1'b0;
    #1;
    ncmp++;
    if (ovld[0] !== 1'b0 || irdy[0] !== 1'b1 || bsy[0] !== 1'b0 || dout[0] !== '0) begin
      nerr++; $display("FAIL async_reset: vld=%b rdy=%b busy=%b data=%h, required 0 1 0 0",
                       ovld[0], irdy[0], bsy[0], dout[0]);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    send(0, 128'(64'h01), 1'b0, lat);
    ncmp++;
    if (dout[0] !== 128'(64'h0100000000000000) || lat !== 24) begin
      nerr++; $display("FAIL after_reset_sort: got %h lat %0d, required 0100000000000000 lat 24",
                       dout[0], lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_back_to_back(input int sel);
    int lat, stalls, n;
    logic [127:0] v, mask, exp, d0;
    logic d;
    bit stable;
    n = NEL[sel];
    mask = (n == 16) ? '1 : ((128'd1 << (n*8)) - 128'd1);
    for (int it = 0; it < 200; it++) begin
      v = {$urandom, $urandom, $urandom, $urandom} & mask;
      if (it % 7 == 3) v = v & {16{8'h03}};  // force duplicates
      d = 1'($urandom_range(0, 1));
      exp = ref_sort(v, n, d);
      ordy[sel] = 1'b0;
      send(sel, v, d, lat);
      ncmp++;
      if (lat !== SLAT[sel]) begin
        nerr++; $display("FAIL rand_latency N=%0d #%0d: got %0d, required %0d", n, it, lat, SLAT[sel]);
      end
      d0 = dout[sel];
      stable = 1;
      stalls = $urandom_range(0, 3);
      repeat (stalls) begin
        @(posedge clk); #1;
        if (ovld[sel] !== 1'b1 || dout[sel] !== d0) stable = 0;
      end
      ncmp++;
      if (dout[sel] !== exp || !stable) begin
        nerr++; $display("FAIL rand_sort N=%0d #%0d: got %h stable=%0b, required %h",
                         n, it, dout[sel], stable, exp);
      end
      ordy[sel] = 1'b1;
      @(posedge clk); #1;
      ordy[sel] = 1'b0;
      ncmp++;
      if (ovld[sel] !== 1'b0 || irdy[sel] !== 1'b1) begin
        nerr++; $display("FAIL rand_release N=%0d #%0d: vld=%b rdy=%b, required 0 1",
                         n, it, ovld[sel], irdy[sel]);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    ivld = '0; idesc = '0; ordy = '0; din = '0;
    test_reset();
    test_sort_basic(1'b0, 64'h0706050403020100);
    test_sort_basic(1'b1, 64'h0001020304050607);
    test_boundary(64'hAAAAAAAAAAAAAAAA, 64'hAAAAAAAAAAAAAAAA, "all_equal");
    test_boundary(64'hFF00FF00FF00FF00, 64'hFFFFFFFF00000000, "extremes");
    test_stall();
    test_mid_reset();
    test_back_to_back(0);
    test_back_to_back(1);
    test_back_to_back(2);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule

// File: doc/bitonic_sort_sched.md
Name: bitonic_sort_sched

Overview:
Sequential scheduler for an 8-lane bitonic sorting network. It time-shares a single registered compare-exchange unit across every compare-exchange step of the network. A vector is accepted over a valid/ready handshake, stepped through all network stages one pair per cycle under a stage/distance/pair counter FSM, and returned over a second valid/ready handshake. It is the area-reduced alternative to the fully combinational sorter for wide elements.

Parameters:
N, 8, element count; power of two, legal values 4, 8, 16
W, 8, element width in bits; unsigned compare
LOGN, $clog2(N), derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  request carries a vector to sort
in_ready  output  1  scheduler can accept a vector
in_data  input  N*W  element e at [e*W +: W]
in_desc  input  1  1 = descending result, 0 = ascending; sampled with in_data
out_valid  output  1  sorted vector available
out_ready  input  1  consumer accepts the vector
out_data  output  N*W  sorted vector, element e at [e*W +: W]
busy  output  1  high in SORT and DONE

Behaviour:
- One clock, clk. rst_n is asynchronous and active-low. Reset values: state=IDLE, in_ready=1, out_valid=0, busy=0, out_data=0, all counters 0, internal array 0.
- FSM states:
  - IDLE: in_ready=1. On in_valid&in_ready, latch in_data into array a[0..N-1], latch in_desc, set k=2, j=1, p=0, then go to SORT.
  - SORT: in_ready=0. Performs exactly one compare-exchange per cycle.
  - DONE: out_valid=1, out_data=a. On out_valid&out_ready, go to IDLE.
- Pair indexing, with j=2^s:
  - i = ((p>>s)<<(s+1)) | (p & (j-1)); partner l = i+j.
  - up = ((i & k)==0) XOR desc.
  - If up and a[i]>a[l], swap. If !up and a[i]<a[l], swap. Equal values are never swapped.
- Counter order, innermost first: p from 0 to N/2-1. Then j halves down to 1. Then k doubles up to N.
  - At p wrap: j=j/2, or when j==1, k=2k and j=k_new/2.
  - The last step is k=N, j=1, p=N/2-1.
- Latency:
  - SORT lasts S=(N/2)*LOGN*(LOGN+1)/2 cycles: N=8 gives 24, N=4 gives 6, N=16 gives 80.
  - The final exchange and the transition to DONE occur on the same edge.
  - out_valid is high S edges after the accepting edge.
- Result order:
  - Ascending: out element 0 is the minimum, element N-1 the maximum.
  - Descending: element 0 is the maximum.
- Handshakes:
  - in_valid while busy is ignored. No data is captured; in_ready stays 0.
  - out_data and out_valid stay stable while out_valid&!out_ready, for any number of cycles.
  - After the output handshake, in_ready=1 on the next cycle. There is no same-cycle re-accept, so minimum turnaround is S+2 cycles per vector.
- in_ready and busy are decoded from registered state only. There is no combinational path from in_valid to in_ready or from out_ready to out_valid.
- Reset mid-SORT or mid-DONE: the vector is discarded, outputs return to reset values immediately, and there is no output handshake for the aborted vector.
- out_data does not change during SORT. It reflects the array only once DONE is reached.

Test Plan:
1. N=8, W=8, in_data elements 0..7 = {5,3,7,0,6,1,4,2}, desc=0, out_ready=1 -> out_valid high exactly 24 cycles after accept; out = {0,1,2,3,4,5,6,7}; in_ready=1 the next cycle.
2. Same vector with desc=1 -> out = {7,6,5,4,3,2,1,0}.
3. All elements 8'hAA; then {0,255,0,255,0,255,0,255} -> first result unchanged; second result {0,0,0,0,255,255,255,255}; this covers the equal-value and extreme-value boundaries.
4. out_ready held low 10 cycles after out_valid rises, with in_valid pulsed during SORT and DONE -> out_data stable through the stall; in_ready=0 throughout; no second vector captured; exactly one output handshake.
5. Deassert rst_n at cycle 12 of SORT -> out_valid=0, in_ready=1, busy=0 asynchronously. After release, a new vector {1,0,0,0,0,0,0,0} sorts to {0,0,0,0,0,0,0,1}.
6. 200 random vectors, back-to-back, random desc, random out_ready stalls; repeat with N=4 and N=16 -> each result matches a scoreboard sort; latency 6 cycles for N=4 and 80 cycles for N=16.
